// File: rtl/riscv_base_pkg.sv
// Shared load-type encodings and the load tag carried from issue to response.
package riscv_base_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] addr;
    } load_tag_t;

endpackage

// File: rtl/riscv_base_writeback_if.sv
// Execute, LSU and register-file write-port signals of the writeback stage.
// Bypass signals exist only when RISCV_WB_BYPASS_EN is defined.
interface riscv_base_writeback_if;

    logic        exec_valid_i;
    logic [4:0]  exec_rd_i;
    logic [31:0] exec_value_i;
    logic        exec_ready_o;

    logic        lsu_req_valid_i;
    logic [4:0]  lsu_req_rd_i;
    logic [2:0]  lsu_req_funct3_i;
    logic [1:0]  lsu_req_addr_i;
    logic        lsu_req_ready_o;

    logic        lsu_resp_valid_i;
    logic [31:0] lsu_resp_data_i;

    logic [4:0]  rd0_o;
    logic [31:0] rd0_value_o;
    logic [31:0] pending_mask_o;
    logic        err_o;

`ifdef RISCV_WB_BYPASS_EN
    logic        byp_valid_o;
    logic [4:0]  byp_rd_o;
    logic [31:0] byp_value_o;
`endif

    modport master (
        output exec_valid_i, exec_rd_i, exec_value_i,
        output lsu_req_valid_i, lsu_req_rd_i, lsu_req_funct3_i, lsu_req_addr_i,
        output lsu_resp_valid_i, lsu_resp_data_i,
`ifdef RISCV_WB_BYPASS_EN
        input  byp_valid_o, byp_rd_o, byp_value_o,
`endif
        input  exec_ready_o, lsu_req_ready_o, rd0_o, rd0_value_o, pending_mask_o, err_o
    );

    modport slave (
        input  exec_valid_i, exec_rd_i, exec_value_i,
        input  lsu_req_valid_i, lsu_req_rd_i, lsu_req_funct3_i, lsu_req_addr_i,
        input  lsu_resp_valid_i, lsu_resp_data_i,
`ifdef RISCV_WB_BYPASS_EN
        output byp_valid_o, byp_rd_o, byp_value_o,
`endif
        output exec_ready_o, lsu_req_ready_o, rd0_o, rd0_value_o, pending_mask_o, err_o
    );

endinterface

// File: rtl/riscv_base_load_align.sv
// Selects the addressed byte/half of an aligned load word and extends it.
// Unknown load types produce zero and raise illegal_o.
module riscv_base_load_align
    import riscv_base_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] value_o,
    output logic        illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = '0;
        half_sel  = addr_i[1] ? data_i[31:16] : data_i[15:0];
        value_o   = '0;
        illegal_o = 1'b0;
        case (addr_i)
            2'd0:    byte_sel = data_i[7:0];
            2'd1:    byte_sel = data_i[15:8];
            2'd2:    byte_sel = data_i[23:16];
            default: byte_sel = data_i[31:24];
        endcase
        case (funct3_i)
            LB:      value_o = {{24{byte_sel[7]}}, byte_sel};
            LH:      value_o = {{16{half_sel[15]}}, half_sel};
            LW:      value_o = data_i;
            LBU:     value_o = {24'd0, byte_sel};
            LHU:     value_o = {16'd0, half_sel};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_base_writeback.sv
// Writeback arbiter: in-order load-tag FIFO, load-over-execute priority, one registered write port.
// Optional combinational bypass of the accepted result under RISCV_WB_BYPASS_EN.
module riscv_base_writeback
    import riscv_base_pkg::*;
#(
    parameter int LOAD_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    riscv_base_writeback_if.slave wb
);

    // Storage is rounded up to a power of two; pointers wrap at LOAD_DEPTH-1.
    localparam int               PTR_W    = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
    localparam int               ENTRIES  = 1 << PTR_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LOAD_DEPTH - 1);

    load_tag_t          tag_q [ENTRIES];
    load_tag_t          tag_d [ENTRIES];
    logic [ENTRIES-1:0] vld_q, vld_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]         rd0_q, rd0_d;
    logic [31:0]        rd0_value_q, rd0_value_d;
    logic               err_q, err_d;

    load_tag_t   head;
    logic        full, empty, push, pop, exec_fire, load_illegal, win_vld;
    logic [4:0]  win_rd;
    logic [31:0] win_value, load_value, pending;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Circular FIFO: full when the write slot is still occupied, empty when the head slot is free.
    assign head      = tag_q[rd_ptr_q];
    assign full      = vld_q[wr_ptr_q];
    assign empty     = ~vld_q[rd_ptr_q];
    assign push      = wb.lsu_req_valid_i & ~full;
    assign pop       = wb.lsu_resp_valid_i & ~empty;
    assign exec_fire = wb.exec_valid_i & ~wb.lsu_resp_valid_i;

    riscv_base_load_align u_align (
        .funct3_i  (head.funct3),
        .addr_i    (head.addr),
        .data_i    (wb.lsu_resp_data_i),
        .value_o   (load_value),
        .illegal_o (load_illegal)
    );

    always_comb begin
        win_vld   = 1'b0;
        win_rd    = '0;
        win_value = '0;
        if (pop) begin
            win_vld   = 1'b1;
            win_rd    = head.rd;
            win_value = load_value;
        end else if (exec_fire) begin
            win_vld   = 1'b1;
            win_rd    = wb.exec_rd_i;
            win_value = wb.exec_value_i;
        end
        if (win_rd == 5'd0) begin
            win_vld   = 1'b0;
            win_value = '0;
        end
    end

    always_comb begin
        tag_d    = tag_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            tag_d[wr_ptr_q] = '{rd: wb.lsu_req_rd_i, funct3: wb.lsu_req_funct3_i,
                                addr: wb.lsu_req_addr_i};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        rd0_d       = win_vld ? win_rd : 5'd0;
        rd0_value_d = win_vld ? win_value : 32'd0;
        err_d       = err_q | (wb.lsu_resp_valid_i & empty) | (pop & load_illegal);
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (vld_q[i]) pending[tag_q[i].rd] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd0_q       <= '0;
            rd0_value_q <= '0;
            err_q       <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd0_q       <= rd0_d;
            rd0_value_q <= rd0_value_d;
            err_q       <= err_d;
        end
    end

    // Tag payload is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        tag_q <= tag_d;
    end

    // During reset the FIFO is about to be empty, so a request is advertised as acceptable.
    assign wb.lsu_req_ready_o = rst_i | ~full;
    assign wb.exec_ready_o    = ~wb.lsu_resp_valid_i;
    assign wb.rd0_o           = rd0_q;
    assign wb.rd0_value_o     = rd0_value_q;
    assign wb.pending_mask_o  = pending;
    assign wb.err_o           = err_q;

`ifdef RISCV_WB_BYPASS_EN
    assign wb.byp_valid_o = win_vld;
    assign wb.byp_rd_o    = win_vld ? win_rd : 5'd0;
    assign wb.byp_value_o = win_vld ? win_value : 32'd0;
`endif

endmodule

// File: tb/tb_riscv_base_writeback.sv
// Directed bench for riscv_base_writeback: expected writes queued at acceptance, checked by a monitor.
module tb_riscv_base_writeback;
    import riscv_base_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    logic [36:0] exp_q[$];

    riscv_base_writeback_if bus ();

    riscv_base_writeback #(.LOAD_DEPTH(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.exec_valid_i     = 1'b0;
        bus.exec_rd_i        = 5'd0;
        bus.exec_value_i     = 32'd0;
        bus.lsu_req_valid_i  = 1'b0;
        bus.lsu_req_rd_i     = 5'd0;
        bus.lsu_req_funct3_i = 3'd0;
        bus.lsu_req_addr_i   = 2'd0;
        bus.lsu_resp_valid_i = 1'b0;
        bus.lsu_resp_data_i  = 32'd0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic exec(input logic [4:0] rd, input logic [31:0] v);
        bus.exec_valid_i = 1'b1;
        bus.exec_rd_i    = rd;
        bus.exec_value_i = v;
    endtask

    task automatic load_req(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a);
        bus.lsu_req_valid_i  = 1'b1;
        bus.lsu_req_rd_i     = rd;
        bus.lsu_req_funct3_i = f3;
        bus.lsu_req_addr_i   = a;
    endtask

    task automatic resp(input logic [31:0] d);
        bus.lsu_resp_valid_i = 1'b1;
        bus.lsu_resp_data_i  = d;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] v);
        exp_q.push_back({rd, v});
    endtask

    // Monitor: every nonzero rd0_o must match the oldest queued write.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.rd0_o !== 5'd0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write_rd", 32'(bus.rd0_o), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_rd", 32'(bus.rd0_o), 32'(e[36:32]));
                        check("wr_value", bus.rd0_value_o, e[31:0]);
                    end
                end else begin
                    check("idle_value", bus.rd0_value_o, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        smp();
        check("rst_exec_ready", 32'(bus.exec_ready_o), 32'd1);
        check("rst_req_ready", 32'(bus.lsu_req_ready_o), 32'd1);
        nxt(); rst = 1'b0; smp();
        check("rst_rd0", 32'(bus.rd0_o), 32'd0);
        check("rst_rd0_value", bus.rd0_value_o, 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_pending", bus.pending_mask_o, 32'd0);
        mon_en = 1'b1;

        // Plain execute write, then an execute to x0.
        nxt(); exec(5'd5, 32'h1234_5678); smp();
        check("exec_ready_idle", 32'(bus.exec_ready_o), 32'd1);
        expect_wr(5'd5, 32'h1234_5678);
        nxt(); exec(5'd0, 32'hDEAD_BEEF); smp();
        check("exec_ready_x0", 32'(bus.exec_ready_o), 32'd1);

        // LB from byte 3 with sign extension, pending bit lifetime.
        nxt(); load_req(5'd7, LB, 2'd3); smp();
        check("req_ready_empty", 32'(bus.lsu_req_ready_o), 32'd1);
        check("pending_before_push", bus.pending_mask_o, 32'd0);
        nxt(); smp();
        check("pending_x7", bus.pending_mask_o, 32'h0000_0080);
        nxt(); resp(32'h80FF_FFFF); smp();
        check("pending_x7_resp_cycle", bus.pending_mask_o, 32'h0000_0080);
        check("exec_ready_resp", 32'(bus.exec_ready_o), 32'd0);
        expect_wr(5'd7, 32'hFFFF_FF80);
        nxt(); smp();
        check("pending_x7_cleared", bus.pending_mask_o, 32'd0);

        // Response beats a same-cycle execute; execute retires a cycle later.
        nxt(); load_req(5'd9, LHU, 2'd2); smp();
        nxt(); exec(5'd3, 32'hAAAA_5555); resp(32'hBEEF_0000); smp();
        check("exec_blocked", 32'(bus.exec_ready_o), 32'd0);
        expect_wr(5'd9, 32'h0000_BEEF);
        nxt(); exec(5'd3, 32'hAAAA_5555); smp();
        check("exec_retry_ready", 32'(bus.exec_ready_o), 32'd1);
        expect_wr(5'd3, 32'hAAAA_5555);

        // Fill the two-entry FIFO; full stays blocked even with a same-cycle pop.
        nxt(); load_req(5'd10, LW, 2'd0); smp();
        check("req_ready_first", 32'(bus.lsu_req_ready_o), 32'd1);
        nxt(); load_req(5'd11, LH, 2'd2); smp();
        check("req_ready_second", 32'(bus.lsu_req_ready_o), 32'd1);
        nxt(); load_req(5'd12, LW, 2'd0); smp();
        check("req_ready_full", 32'(bus.lsu_req_ready_o), 32'd0);
        check("pending_two", bus.pending_mask_o, 32'h0000_0C00);
        nxt(); load_req(5'd12, LW, 2'd0); resp(32'h1122_3344); smp();
        check("req_ready_full_pop", 32'(bus.lsu_req_ready_o), 32'd0);
        expect_wr(5'd10, 32'h1122_3344);
        nxt(); resp(32'h8001_7FFF); smp();
        check("req_ready_after_pop", 32'(bus.lsu_req_ready_o), 32'd1);
        check("pending_x11_only", bus.pending_mask_o, 32'h0000_0800);
        expect_wr(5'd11, 32'hFFFF_8001);
        nxt(); smp();
        check("pending_drained", bus.pending_mask_o, 32'd0);

        // LBU, load to x0 (masked pending bit, no write), positive LB.
        nxt(); load_req(5'd13, LBU, 2'd1); smp();
        nxt(); load_req(5'd0, LW, 2'd0); smp();
        nxt(); smp();
        check("pending_x0_masked", bus.pending_mask_o, 32'h0000_2000);
        nxt(); resp(32'h0000_9A00); smp();
        expect_wr(5'd13, 32'h0000_009A);
        nxt(); resp(32'hFFFF_FFFF); smp();
        nxt(); load_req(5'd14, LB, 2'd0); smp();
        nxt(); resp(32'h1234_567F); smp();
        expect_wr(5'd14, 32'h0000_007F);
        nxt(); smp();
        check("err_clean", 32'(bus.err_o), 32'd0);
        check("pending_idle", bus.pending_mask_o, 32'd0);

        // Response with empty FIFO: dropped, sticky error.
        nxt(); resp(32'h0000_0055); exec(5'd6, 32'h0000_0066); smp();
        check("exec_blocked_empty_resp", 32'(bus.exec_ready_o), 32'd0);
        nxt(); smp();
        check("err_empty_resp", 32'(bus.err_o), 32'd1);
        nxt(); smp();
        check("err_sticky", 32'(bus.err_o), 32'd1);

        // Reset with two outstanding tags discards them.
        nxt(); load_req(5'd20, LW, 2'd0); smp();
        nxt(); load_req(5'd21, LW, 2'd0); smp();
        nxt(); smp();
        check("pending_before_rst", bus.pending_mask_o, 32'h0030_0000);
        check("req_ready_full_before_rst", 32'(bus.lsu_req_ready_o), 32'd0);
        nxt(); rst = 1'b1; smp();
        check("req_ready_in_rst", 32'(bus.lsu_req_ready_o), 32'd1);
        check("exec_ready_in_rst", 32'(bus.exec_ready_o), 32'd1);
        nxt(); rst = 1'b0; smp();
        check("pending_after_rst", bus.pending_mask_o, 32'd0);
        check("err_after_rst", 32'(bus.err_o), 32'd0);
        check("req_ready_after_rst", 32'(bus.lsu_req_ready_o), 32'd1);
        nxt(); resp(32'hCAFE_F00D); smp();
        nxt(); smp();
        check("err_resp_after_rst", 32'(bus.err_o), 32'd1);

        // Unknown funct3 writes zero and raises the error flag.
        nxt(); rst = 1'b1; smp();
        nxt(); rst = 1'b0; smp();
        check("err_cleared", 32'(bus.err_o), 32'd0);
        nxt(); load_req(5'd15, 3'b011, 2'd0); smp();
        nxt(); resp(32'hFFFF_FFFF); smp();
        expect_wr(5'd15, 32'h0000_0000);
        nxt(); smp();
        check("err_illegal_funct3", 32'(bus.err_o), 32'd1);

        nxt(); smp();
        nxt(); smp();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_base_writeback.md
RISCV_BASE_WRITEBACK -- requirements
Module: riscv_base_writeback

Interface
REQ-001 Parameter LOAD_DEPTH, default 2, is the number of outstanding loads tracked (legal values 1..4).
REQ-002 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 exec_valid_i / exec_rd_i / exec_value_i  in  1/5/32  single-cycle execute result offered.
REQ-005 exec_ready_o  out  1  execute result accepted when exec_valid_i and exec_ready_o are both high.
REQ-006 lsu_req_valid_i / lsu_req_rd_i / lsu_req_funct3_i / lsu_req_addr_i  in  1/5/3/2  load issued: destination, load type, byte offset.
REQ-007 lsu_req_ready_o  out  1  load tag accepted on valid&ready.
REQ-008 lsu_resp_valid_i / lsu_resp_data_i  in  1/32  raw aligned-word load response, in issue order, no backpressure.
REQ-009 rd0_o / rd0_value_o  out  5/32  registered write port driving the register file (rd0_o=0 means no write).
REQ-010 pending_mask_o  out  32  bit n high while any tracked load targets xn; bit 0 always 0.
REQ-011 err_o  out  1  sticky protocol-error flag.

Function
REQ-012 Load tags shall be held in an in-order FIFO of LOAD_DEPTH entries {rd, funct3, addr}; push on lsu_req fire, pop on lsu_resp_valid_i.
REQ-013 lsu_req_ready_o shall be high iff the FIFO is not full; a push and pop in the same cycle on a full FIFO shall not be accepted (ready stays low).
REQ-014 Load data shall be extracted by head-tag funct3/addr: LB/LH sign-extend, LBU/LHU zero-extend, LW passes; LH/LHU use addr[1]; other funct3 codes yield 0 and set err_o.
REQ-015 A load response shall have priority over execute: in that cycle exec_ready_o = 0; otherwise exec_ready_o = 1.
REQ-016 The winning result shall appear on rd0_o/rd0_value_o exactly one cycle after acceptance (latency 1); with no winner, rd0_o = 0 and rd0_value_o = 0 next cycle.
REQ-017 A result with destination x0 shall be forwarded as rd0_o = 0, rd0_value_o = 0.
REQ-018 pending_mask_o shall be the combinational OR of one-hot(rd) over valid FIFO entries, with bit 0 masked.
REQ-019 lsu_resp_valid_i with an empty FIFO shall be dropped (no write, no pop) and set err_o.
REQ-020 err_o shall remain set until reset.

Reset
REQ-021 While rst_i is high at a clock edge: FIFO emptied, rd0_o = 0, rd0_value_o = 0, err_o = 0; pending_mask_o = 0 from the next cycle.
REQ-022 Reset mid-operation shall discard all outstanding tags; responses arriving afterwards follow REQ-019.
REQ-023 Combinational outputs during reset: lsu_req_ready_o and exec_ready_o follow REQ-013/015 from the post-reset state.

Configuration
REQ-024 With RISCV_WB_BYPASS_EN defined, outputs byp_valid_o (1), byp_rd_o (5), byp_value_o (32) shall present, combinationally, the result being accepted this cycle (byp_valid_o = 0 when none or rd = 0).
REQ-025 Without RISCV_WB_BYPASS_EN the bypass ports and logic shall not exist; all other behaviour is unchanged.

Structure
REQ-026 Load funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101) and the tag struct type shall live in shared package riscv_base_pkg.
REQ-027 Byte/half extraction and extension shall be sub-module riscv_base_load_align (purely combinational); FIFO and arbitration stay in the top.

Verification
REQ-028 Exec x5 = 0x1234_5678, no load -> next cycle rd0_o = 5, rd0_value_o = 0x1234_5678, exec_ready_o = 1.
REQ-029 Load tag {rd=7, LB, addr=3}, resp 0x80FF_FFFF -> rd0_o = 7, rd0_value_o = 0xFFFF_FF80; pending_mask_o bit 7 high from tag to resp cycle, then low.
REQ-030 Same-cycle exec x3 and resp for LHU addr=2, data 0xBEEF_0000 -> exec_ready_o = 0; rd0 = {x?, 0x0000_BEEF}; exec x3 written one cycle later.
REQ-031 LOAD_DEPTH=2: two tags pushed, third request -> lsu_req_ready_o = 0; responses retire in issue order.
REQ-032 Resp with empty FIFO -> no write, err_o = 1 until rst_i; rst_i with 2 pending tags -> pending_mask_o = 0 and FIFO empty.
